trb_mem_responder: RTL

Memory-side responder for the trace logger's read/write pointer interface. It owns the trace ring-buffer RAM (TRB_DEPTH x TRB_WIDTH) and generates the alternating RW turn strobe. It gates writes and reads with allow signals and serves registered read data. A clear sequencer zero-fills the RAM before tracing/streaming starts. It sits between the logger and the physical RAM, in the logger clock domain.

---
 rtl/trb_mem_responder_pkg.sv | 15 +
 rtl/trb_mem_responder_if.sv | 29 ++
 rtl/trb_mem_responder_dpram.sv | 24 ++
 rtl/trb_mem_responder.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/trb_mem_responder_pkg.sv
// Shared geometry and state encoding for the trace ring-buffer responder.
// Optional parity storage: define TRB_MEM_PARITY_EN.
package trb_mem_responder_pkg;

  localparam int TRB_WIDTH      = 8;
  localparam int TRB_DEPTH      = 16;
  localparam int TRB_ADDR_WIDTH = $clog2(TRB_DEPTH);

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_CLEAR,
    MEM_RUN
  } mem_state_t;

endpackage

// File: rtl/trb_mem_responder_if.sv
// Logger <-> responder pointer/data bundle.
// master = logger side, slave = memory responder.
interface trb_mem_responder_if;
  import trb_mem_responder_pkg::*;

  logic                      RW_TURN_O;
  logic                      WRITE_I;
  logic [TRB_ADDR_WIDTH-1:0] WRITE_PTR_I;
  logic [TRB_WIDTH-1:0]      DMEM_I;
  logic [TRB_ADDR_WIDTH-1:0] READ_PTR_I;
  logic [TRB_WIDTH-1:0]      DMEM_O;
  logic                      WRITE_ALLOW_O;
  logic                      READ_ALLOW_O;

  modport master (
    input  RW_TURN_O, DMEM_O,
    input  WRITE_ALLOW_O, READ_ALLOW_O,
    output WRITE_I, WRITE_PTR_I,
    output DMEM_I, READ_PTR_I
  );

  modport slave (
    output RW_TURN_O, DMEM_O,
    output WRITE_ALLOW_O, READ_ALLOW_O,
    input  WRITE_I, WRITE_PTR_I,
    input  DMEM_I, READ_PTR_I
  );

endinterface

// File: rtl/trb_mem_responder_dpram.sv
// 1-write/1-read synchronous RAM, registered read.
// Contents and read register are not reset.
module trb_dpram #(
  parameter int W = 8,
  parameter int D = 16,
  parameter int AW = $clog2(D)
) (
  input  logic          CLK_I,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [D];

  always_ff @(posedge CLK_I) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trb_mem_responder.sv
// Trace ring-buffer responder: turn strobe, allows, clear sequencer.
// Optional parity storage and checking: define TRB_MEM_PARITY_EN.
module trb_mem_responder
  import trb_mem_responder_pkg::*;
(
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                EN_I,
  input  logic                CLEAR_I,
  input  logic                HOLD_I,
  trb_mem_responder_if.slave  bus,
  output logic                BUSY_O,
  output logic                ERR_O,
  output logic                PARITY_ERR_O
);

`ifdef TRB_MEM_PARITY_EN
  localparam int RW = TRB_WIDTH + 1;
`else
  localparam int RW = TRB_WIDTH;
`endif

  mem_state_t                state;
  logic                      turn;
  logic                      err;
  logic                      byp;
  logic [TRB_WIDTH-1:0]      byp_d;
  logic [TRB_ADDR_WIDTH-1:0] cnt;

  logic                      allow;
  logic                      wr_ok;
  logic                      hit;
  logic                      pf;
  logic                      re;
  logic                      we;
  logic                      clr_wr;
  logic [TRB_ADDR_WIDTH-1:0] waddr;
  logic [RW-1:0]             wdata;
  logic [RW-1:0]             rdata;
  logic [RW-1:0]             udata;

  assign allow  = (state == MEM_RUN) && !HOLD_I;
  assign wr_ok  = turn && bus.WRITE_I && allow;
  assign hit    = wr_ok &&
                  (bus.WRITE_PTR_I == bus.READ_PTR_I);
  assign pf     = (state == MEM_RUN) && turn;
  assign re     = pf && !RST_I && !CLEAR_I;
  assign clr_wr = state == MEM_CLEAR;
  assign we     = !RST_I && (clr_wr || wr_ok);
  assign waddr  = clr_wr ? cnt : bus.WRITE_PTR_I;

`ifdef TRB_MEM_PARITY_EN
  assign udata = {^bus.DMEM_I, bus.DMEM_I};
`else
  assign udata = bus.DMEM_I;
`endif
  assign wdata = clr_wr ? '0 : udata;

  trb_dpram #(
    .W (RW),
    .D (TRB_DEPTH)
  ) u_ram (
    .CLK_I (CLK_I),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (bus.READ_PTR_I),
    .rdata (rdata)
  );

  // Reset selects the zeroed bypass word so DMEM_O reads 0.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= MEM_IDLE;
      turn  <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
      byp   <= 1'b1;
      byp_d <= '0;
    end else if (CLEAR_I) begin
      state <= MEM_CLEAR;
      turn  <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      if (bus.WRITE_I && !wr_ok) err <= 1'b1;
      if (pf) begin
        byp   <= hit;
        byp_d <= bus.DMEM_I;
      end
      unique case (state)
        MEM_IDLE: begin
          if (EN_I) begin
            state <= MEM_RUN;
            turn  <= 1'b1;
          end
        end
        MEM_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state <= EN_I ? MEM_RUN : MEM_IDLE;
            turn  <= EN_I;
          end
        end
        MEM_RUN: begin
          if (!EN_I) begin
            state <= MEM_IDLE;
            turn  <= 1'b0;
          end else begin
            turn <= ~turn;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

`ifdef TRB_MEM_PARITY_EN
  logic chk;
  logic perr_q;
  logic perr_now;

  // Only RAM-sourced words are checked; bypassed data never is.
  assign perr_now = chk &&
    (^rdata[TRB_WIDTH-1:0] != rdata[TRB_WIDTH]);

  always_ff @(posedge CLK_I) begin
    if (RST_I || CLEAR_I) begin
      chk    <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_q | perr_now;
      if (pf) chk <= !hit;
    end
  end

  assign PARITY_ERR_O = perr_q | perr_now;
`else
  assign PARITY_ERR_O = 1'b0;
`endif

  assign bus.RW_TURN_O     = turn;
  assign bus.WRITE_ALLOW_O = allow;
  assign bus.READ_ALLOW_O  = allow;
  assign bus.DMEM_O = byp ? byp_d : rdata[TRB_WIDTH-1:0];
  assign BUSY_O = state == MEM_CLEAR;
  assign ERR_O  = err;

endmodule
